// File: rtl/ram_bist_ctrl.sv
// Two-pass march-style BIST controller for a synchronous RAM with 1-cycle read latency.
// Optional macro RAM_BIST_ABORT_EN: stop the run at the first mismatch.
module ram_bist_ctrl #(
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] direccion,
    output logic [DATA_W-1:0] Dato_E,
    output logic              EN,
    input  logic [DATA_W-1:0] dato_s,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              pass_reg, pass_next;
    logic [7:0]        err_reg, err_next;
    logic              fail_reg, fail_next;
    logic [ADDR_W-1:0] fail_addr_reg, fail_addr_next;
    logic [DATA_W-1:0] pat_value;
    logic              mismatch;

    // Pass 0 writes addr^PATTERN, pass 1 its complement, so every cell sees both polarities.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic p);
        logic [DATA_W-1:0] v;
        v = DATA_W'(a) ^ PATTERN;
        return p ? ~v : v;
    endfunction

    assign pat_value = pat(addr_reg, pass_reg);
    assign mismatch  = (dato_s != pat_value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            pass_reg      <= 1'b0;
            err_reg       <= '0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            pass_reg      <= pass_next;
            err_reg       <= err_next;
            fail_reg      <= fail_next;
            fail_addr_reg <= fail_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        pass_next      = pass_reg;
        err_next       = err_reg;
        fail_next      = fail_reg;
        fail_addr_next = fail_addr_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = WR;
                    addr_next      = '0;
                    pass_next      = 1'b0;
                    err_next       = '0;
                    fail_next      = 1'b0;
                    fail_addr_next = '0;
                end
            end
            WR: begin
                addr_next = addr_reg + 1'b1;
                if (addr_reg == LAST_ADDR) state_next = RD;
            end
            RD: state_next = CMP;
            CMP: begin
                if (mismatch) begin
                    if (err_reg != 8'hFF) err_next = err_reg + 8'd1;
                    fail_next = 1'b1;
                    if (!fail_reg) fail_addr_next = addr_reg;
                end
                if (addr_reg != LAST_ADDR) begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = RD;
                end else if (!pass_reg) begin
                    pass_next  = 1'b1;
                    addr_next  = '0;
                    state_next = WR;
                end else begin
                    state_next = DONE;
                end
`ifdef RAM_BIST_ABORT_EN
                // First mismatch ends the run; err_count is 1 because no earlier failure existed.
                if (mismatch) begin
                    state_next = DONE;
                    addr_next  = addr_reg;
                    pass_next  = pass_reg;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign direccion = addr_reg;
    assign EN        = (state_reg == WR);
    assign Dato_E    = (state_reg == WR) ? pat_value : '0;
    assign busy      = (state_reg == WR) || (state_reg == RD) || (state_reg == CMP);
    assign done      = (state_reg == DONE);
    assign fail      = fail_reg;
    assign err_count = err_reg;
    assign fail_addr = fail_addr_reg;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: RAM model with injectable faults, bus-sequence
// monitor, per-run scoreboard of expected completion results.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] direccion;
    logic [7:0] Dato_E;
    logic       EN;
    logic [7:0] dato_s;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] err_count;
    logic [7:0] fail_addr;

    int checks = 0;
    int failures = 0;

    ram_bist_ctrl #(.ADDR_W(8), .DATA_W(8), .PATTERN(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .direccion(direccion),
        .Dato_E(Dato_E), .EN(EN), .dato_s(dato_s), .busy(busy), .done(done),
        .fail(fail), .err_count(err_count), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    // RAM model: 0 = good, 1 = bit0 of address 9 stuck at 0, 2 = reads always 0x00
    int         fault = 0;
    logic [7:0] mem [256];
    logic [7:0] rd_q = 8'h00;
    assign dato_s = rd_q;

    always @(posedge clk) begin
        if (EN) mem[direccion] <= (fault == 1 && direccion == 8'd9) ? (Dato_E & 8'hFE) : Dato_E;
        rd_q <= (fault == 2) ? 8'h00 : mem[direccion];
    end

    function automatic logic [7:0] exp_pat(input int a, input int p);
        logic [7:0] v;
        v = a[7:0] ^ 8'hA5;
        return (p != 0) ? ~v : v;
    endfunction

    // Bus monitor: expected EN/direccion/Dato_E for cycle c after the start-sampling edge
    bit mon_active = 1'b0;
    int mon_c = 0;
    int mon_bad = 0;
    bit watch_en = 1'b0;
    int en_bad = 0;

    always @(negedge clk) begin
        if (mon_active) begin
            int p, r, ea;
            logic ee;
            logic [7:0] ed;
            p = mon_c / 768;
            r = mon_c % 768;
            if (r < 256) begin
                ee = 1'b1; ea = r; ed = exp_pat(r, p);
            end else begin
                ee = 1'b0; ea = (r - 256) / 2; ed = 8'h00;
            end
            if (EN !== ee || direccion !== ea[7:0] || Dato_E !== ed) mon_bad++;
            mon_c++;
        end
        if (watch_en && EN !== 1'b0) en_bad++;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    typedef struct {
        int fault;
        int r1;
        int r2;
        int cycles;
        int errs;
        int fl;
        int faddr;
    } vec_t;

    typedef struct {
        int cycles;
        int errs;
        int fl;
        int faddr;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[4];

    task automatic run_vec(input vec_t v, input string tag);
        int   cyc;
        bit   got;
        int   busy_bad;
        exp_t e;
        fault = v.fault;
        exp_q.push_back('{v.cycles, v.errs, v.fl, v.faddr});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mon_c = 0;
        mon_bad = 0;
        mon_active = 1'b1;
        cyc = 0;
        got = 1'b0;
        busy_bad = 0;
        while (cyc < 4000 && !got) begin
            @(posedge clk);
            cyc++;
            #1;
            start = (cyc == v.r1 || cyc == v.r2);
            if (done) got = 1'b1;
            else if (!busy) busy_bad++;
        end
        mon_active = 1'b0;
        start = 1'b0;
        chk({tag, "_done_seen"}, int'(got), 1);
        e = exp_q.pop_front();
        chk({tag, "_cycles"}, cyc, e.cycles);
        chk({tag, "_err_count"}, int'(err_count), e.errs);
        chk({tag, "_fail"}, int'(fail), e.fl);
        chk({tag, "_fail_addr"}, int'(fail_addr), e.faddr);
        chk({tag, "_bus_errors"}, mon_bad, 0);
        chk({tag, "_busy_gaps"}, busy_bad, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_held"}, int'({done, busy, EN}), 3'b100);
        chk({tag, "_err_held"}, int'(err_count), e.errs);
        $display("run %s fault=%0d cycles=%0d err_count=%0d fail=%0d fail_addr=%0d",
                 tag, v.fault, cyc, err_count, fail, fail_addr);
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 1536, 0, 0, 0};
`ifdef RAM_BIST_ABORT_EN
        vecs[1] = '{1, 0, 0, 1044, 1, 1, 9};
        vecs[2] = '{2, 0, 0, 258, 1, 1, 0};
`else
        vecs[1] = '{1, 0, 0, 1536, 1, 1, 9};
        vecs[2] = '{2, 0, 0, 1536, 255, 1, 0};
`endif
        vecs[3] = '{0, 10, 800, 1536, 0, 0, 0};

        #1;
        chk("reset_outputs", int'({direccion, Dato_E, EN, busy, done, fail, err_count, fail_addr}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset", int'({busy, done, EN}), 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a failing run: outputs must clear asynchronously.
        fault = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("pre_reset_err_nonzero", int'(err_count != 0), 1);
        rst_n = 1'b0;
        en_bad = 0;
        watch_en = 1'b1;
        #1;
        chk("midrun_reset_bus", int'({direccion, Dato_E, EN}), 0);
        chk("midrun_reset_status", int'({busy, done, fail, err_count, fail_addr}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        watch_en = 1'b0;
        chk("no_write_after_reset", en_bad, 0);
        chk("idle_wait_after_reset", int'({busy, done, fail}), 0);
        $display("run midrun_reset en_writes=%0d busy=%0d done=%0d", en_bad, busy, done);

        run_vec(vecs[0], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of the RAM address bus.
REQ-002 SHALL have parameter DATA_W, default 8: width of the RAM data buses.
REQ-003 SHALL have parameter PATTERN, default 8'hA5 (DATA_W bits): pattern seed.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes occur on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: run request, sampled only in IDLE or DONE.
REQ-007 SHALL have port direccion, output, ADDR_W: RAM address.
REQ-008 SHALL have port Dato_E, output, DATA_W: RAM write data.
REQ-009 SHALL have port EN, output, 1: RAM write enable (1 = write, 0 = read).
REQ-010 SHALL have port dato_s, input, DATA_W: RAM read data, registered by the RAM (1-cycle latency).
REQ-011 SHALL have port busy, output, 1: test in progress.
REQ-012 SHALL have port done, output, 1: test finished; held until the next accepted start.
REQ-013 SHALL have port fail, output, 1: at least one mismatch in the last run.
REQ-014 SHALL have port err_count, output, 8: mismatch count, saturating at 255.
REQ-015 SHALL have port fail_addr, output, ADDR_W: address of the first mismatch in the run.

Function
REQ-016 SHALL use the pattern function pat(a,p) = (a XOR PATTERN) for pass p=0 and the bitwise inverse of that value for pass p=1, with a zero-extended to DATA_W.
REQ-017 SHALL implement states IDLE, WR, RD, CMP and DONE.
REQ-018 IDLE/DONE: EN=0 and busy=0; start=1 -> WR with addr=0, pass=0, err_count=0, fail=0, fail_addr=0 and done=0.
REQ-019 WR: EN=1, direccion=addr, Dato_E=pat(addr,pass); addr increments every cycle; at addr=2^ADDR_W-1, wrap addr to 0 and go to RD.
REQ-020 RD: EN=0, direccion=addr, Dato_E=0; the next state is always CMP.
REQ-021 CMP: EN=0, direccion held; compare dato_s with pat(addr,pass); on a mismatch, increment err_count (saturating) and set fail; the first mismatch of the run loads fail_addr=addr.
REQ-022 CMP exit: if addr is not last, increment addr and go to RD; if last and pass=0, set pass=1, addr=0 and go to WR; if last and pass=1, go to DONE with done=1.
REQ-023 Busy duration SHALL be exactly 6*2^ADDR_W cycles (1536 at default), counted from the edge that samples start to the first cycle with done=1.
REQ-024 start asserted while busy=1 SHALL be ignored, with no effect on state, counters or outputs.
REQ-025 err_count SHALL hold at 255 once reached, while fail_addr remains the first failing address.
REQ-026 EN SHALL never be 1 outside the WR state.

Reset
REQ-027 While rst_n=0, the block SHALL immediately enter IDLE with direccion=0, Dato_E=0, EN=0, busy=0, done=0, fail=0, err_count=0 and fail_addr=0.
REQ-028 Reset asserted mid-run SHALL abort the test with no further RAM writes; after release the block SHALL wait in IDLE for start.

Configuration
REQ-029 Macro RAM_BIST_ABORT_EN, when defined, SHALL make the first mismatch in CMP go directly to DONE with fail=1, err_count=1, fail_addr=that address and done=1.
REQ-030 Without RAM_BIST_ABORT_EN, the block SHALL always complete both passes per REQ-022/023.

Verification
REQ-031 Good RAM model, defaults: pulse start -> busy for 1536 cycles, then done=1, fail=0, err_count=0.
REQ-032 RAM model with bit0 of address 9 stuck at 0 -> pass 0 passes (0xAC), pass 1 fails (expects 0x53); end state err_count=1, fail=1, fail_addr=9.
REQ-033 Model always returning 0x00 -> 510 raw mismatches; err_count=255, fail=1, fail_addr=0x00.
REQ-034 rst_n low at cycle 300 of a run -> all outputs are reset values within the same cycle, with no EN=1 after reset; a new start runs a full clean test.
REQ-035 start re-pulsed at cycles 10 and 800 of a run -> ignored; done still arrives at cycle 1536.
REQ-036 With RAM_BIST_ABORT_EN and the REQ-032 fault -> done=1 at cycle 768+256+2*9+2 = 1044, with err_count=1 and fail_addr=9.
